// File: rtl/i2c_fifo_pkg.sv
// ============================================================================
// i2c_fifo_pkg : shared types and constants for the I2C transmit FIFO slice.
// Revision 1.0 : initial release.
// ============================================================================
`default_nettype none

package i2c_fifo_pkg;

   typedef logic [8:0] i2c_data_cmd_t;

   localparam logic CMD_READ  = 1'b1;
   localparam logic CMD_WRITE = 1'b0;

   localparam int unsigned TX_FIFO_DEPTH = 8;

   // Thresholds at or beyond the FIFO depth behave as DEPTH-1.
   function automatic int unsigned clamp_tl(input int unsigned tl, input int unsigned depth);
      return (tl >= depth) ? (depth - 1) : tl;
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_fifo_mem.sv
// ============================================================================
// i2c_fifo_mem : DEPTH x DW register array, one sync write port, one async read port.
// Revision 1.0 : initial release.
// ============================================================================
`default_nettype none

module i2c_fifo_mem #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 9,
   parameter int unsigned AW    = 3
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/i2c_tx_fifo_ctrl.sv
// ============================================================================
// i2c_tx_fifo_ctrl : I2C TX FIFO control (pointers, level, flags, sticky overflow).
// Revision 1.0 : optional abort flush enabled by macro I2C_TX_ABORT_FLUSH_EN.
// ============================================================================
`default_nettype none

module i2c_tx_fifo_ctrl
   import i2c_fifo_pkg::*;
#(
   parameter  int unsigned DEPTH = TX_FIFO_DEPTH,
   parameter  int unsigned DW    = 9,
   localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
   input  logic          pclk_i,
   input  logic          presetn_i,
   input  logic          ic_enable_i,
`ifdef I2C_TX_ABORT_FLUSH_EN
   input  logic          tx_abort_i,
`endif
   input  logic          tx_push_i,
   input  logic [DW-1:0] tx_push_data_i,
   input  logic          tx_pop_i,
   output logic [DW-1:0] tx_pop_data_o,
   input  logic [LW-1:0] tx_tl_i,
   input  logic          clr_tx_over_i,
   output logic          tx_full_o,
   output logic          tx_empty_o,
   output logic          tx_empty_intr_o,
   output logic          tx_over_o,
   output logic [LW-1:0] tx_level_o
);

   localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;
   logic          tx_over_q, tx_over_d;

   logic          flush;
   logic          full;
   logic          empty;
   logic          push_ok;
   logic          pop_ok;
   logic          overflow;
   logic [LW-1:0] tl_eff;
   logic [DW-1:0] head_data;

`ifdef I2C_TX_ABORT_FLUSH_EN
   assign flush = ~ic_enable_i | tx_abort_i;
`else
   assign flush = ~ic_enable_i;
`endif

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);

   // A full FIFO is never empty, so a pop in the same cycle always frees a slot.
   assign push_ok  = tx_push_i & (~full | tx_pop_i) & ~flush;
   assign pop_ok   = tx_pop_i & ~empty & ~flush;
   assign overflow = tx_push_i & full & ~tx_pop_i & ~flush;

   assign tl_eff = LW'(clamp_tl(32'(tx_tl_i), DEPTH));

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      tx_over_d = tx_over_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end

      // Setting the sticky flag wins over a simultaneous clear.
      if (overflow) begin
         tx_over_d = 1'b1;
      end else if (clr_tx_over_i) begin
         tx_over_d = 1'b0;
      end
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         tx_over_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         tx_over_q <= tx_over_d;
      end
   end

   i2c_fifo_mem #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_mem (
      .clk_i   (pclk_i),
      .we_i    (push_ok),
      .waddr_i (wr_ptr_q),
      .wdata_i (tx_push_data_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_data)
   );

   assign tx_pop_data_o   = empty ? '0 : head_data;
   assign tx_full_o       = full;
   assign tx_empty_o      = empty;
   assign tx_empty_intr_o = (level_q <= tl_eff);
   assign tx_over_o       = tx_over_q;
   assign tx_level_o      = level_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_tx_fifo_ctrl.sv
// ============================================================================
// tb_i2c_tx_fifo_ctrl : directed self-checking bench for i2c_tx_fifo_ctrl (DEPTH=8).
// Revision 1.0 : abort flush steps included when I2C_TX_ABORT_FLUSH_EN is defined.
// ============================================================================
`default_nettype none

module tb_i2c_tx_fifo_ctrl;
   import i2c_fifo_pkg::*;

   localparam int DEPTH = 8;
   localparam int LW    = 4;

   logic          clk = 1'b0;
   logic          presetn;
   logic          ic_enable;
   logic          tx_push;
   i2c_data_cmd_t tx_push_data;
   logic          tx_pop;
   i2c_data_cmd_t tx_pop_data;
   logic [LW-1:0] tx_tl;
   logic          clr_tx_over;
   logic          tx_full;
   logic          tx_empty;
   logic          tx_empty_intr;
   logic          tx_over;
   logic [LW-1:0] tx_level;
`ifdef I2C_TX_ABORT_FLUSH_EN
   logic          tx_abort;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   i2c_tx_fifo_ctrl #(
      .DEPTH (DEPTH),
      .DW    (9)
   ) dut (
      .pclk_i          (clk),
      .presetn_i       (presetn),
      .ic_enable_i     (ic_enable),
`ifdef I2C_TX_ABORT_FLUSH_EN
      .tx_abort_i      (tx_abort),
`endif
      .tx_push_i       (tx_push),
      .tx_push_data_i  (tx_push_data),
      .tx_pop_i        (tx_pop),
      .tx_pop_data_o   (tx_pop_data),
      .tx_tl_i         (tx_tl),
      .clr_tx_over_i   (clr_tx_over),
      .tx_full_o       (tx_full),
      .tx_empty_o      (tx_empty),
      .tx_empty_intr_o (tx_empty_intr),
      .tx_over_o       (tx_over),
      .tx_level_o      (tx_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [8:0] d);
      tx_push      = 1'b1;
      tx_push_data = d;
      step();
      tx_push      = 1'b0;
   endtask

   task automatic pop_word();
      tx_pop = 1'b1;
      step();
      tx_pop = 1'b0;
   endtask

   initial begin
      presetn      = 1'b0;
      ic_enable    = 1'b1;
      tx_push      = 1'b0;
      tx_push_data = '0;
      tx_pop       = 1'b0;
      tx_tl        = '0;
      clr_tx_over  = 1'b0;
`ifdef I2C_TX_ABORT_FLUSH_EN
      tx_abort     = 1'b0;
`endif

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", 32'(tx_empty), 32'd1);
      check("rst_full",  32'(tx_full),  32'd0);
      check("rst_level", 32'(tx_level), 32'd0);
      check("rst_over",  32'(tx_over),  32'd0);
      check("rst_intr",  32'(tx_empty_intr), 32'd1);
      check("rst_data",  32'(tx_pop_data), 32'd0);
      presetn = 1'b1;
      step();

      // Three-cycle push of 0x0A5, threshold 2
      tx_tl        = 4'd2;
      tx_push      = 1'b1;
      tx_push_data = 9'h0A5;
      step();
      step();
      check("t1_lvl2_intr", 32'(tx_empty_intr), 32'd1);
      step();
      tx_push = 1'b0;
      check("t1_level", 32'(tx_level), 32'd3);
      check("t1_intr",  32'(tx_empty_intr), 32'd0);
      check("t1_empty", 32'(tx_empty), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("t1_head", 32'(tx_pop_data), 32'h0A5);
         pop_word();
      end
      check("t1_drained", 32'(tx_empty), 32'd1);
      check("t1_data0",   32'(tx_pop_data), 32'd0);

      // Fill past full: 9th word dropped, overflow sticky
      for (int i = 1; i <= 8; i++) push_word(9'(i));
      check("t2_full",  32'(tx_full),  32'd1);
      check("t2_level", 32'(tx_level), 32'd8);
      check("t2_over_pre", 32'(tx_over), 32'd0);
      push_word(9'h009);
      check("t2_level9", 32'(tx_level), 32'd8);
      check("t2_over",   32'(tx_over),  32'd1);
      tx_push      = 1'b1;
      tx_push_data = 9'h055;
      clr_tx_over  = 1'b1;
      step();
      tx_push = 1'b0;
      check("t2_set_wins", 32'(tx_over), 32'd1);
      step();
      clr_tx_over = 1'b0;
      check("t2_clr", 32'(tx_over), 32'd0);

      // Drain in order, pop-on-empty, wrap then push 0x1FF
      for (int i = 1; i <= 8; i++) begin
         check("t3_order", 32'(tx_pop_data), 32'(i));
         pop_word();
      end
      check("t3_empty", 32'(tx_empty), 32'd1);
      pop_word();
      check("t3_pop_empty_lvl",  32'(tx_level), 32'd0);
      check("t3_pop_empty_over", 32'(tx_over),  32'd0);
      push_word(9'h1FF);
      check("t3_wrap_head",  32'(tx_pop_data), 32'h1FF);
      check("t3_wrap_level", 32'(tx_level),    32'd1);
      pop_word();

      // Push+pop on empty, then push+pop on full
      tx_push      = 1'b1;
      tx_pop       = 1'b1;
      tx_push_data = 9'h033;
      step();
      tx_push = 1'b0;
      tx_pop  = 1'b0;
      check("t4_empty_pp_lvl",  32'(tx_level),    32'd1);
      check("t4_empty_pp_head", 32'(tx_pop_data), 32'h033);
      for (int i = 0; i < 7; i++) push_word(9'h040 + 9'(i));
      check("t4_full", 32'(tx_full), 32'd1);
      tx_tl = 4'd15;
      #1;
      check("t4_tl_clamp_full", 32'(tx_empty_intr), 32'd0);
      tx_push      = 1'b1;
      tx_pop       = 1'b1;
      tx_push_data = 9'h1AB;
      step();
      tx_push = 1'b0;
      tx_pop  = 1'b0;
      check("t4_full_pp_lvl",  32'(tx_level),    32'd8);
      check("t4_full_pp_over", 32'(tx_over),     32'd0);
      check("t4_full_pp_head", 32'(tx_pop_data), 32'h040);
      pop_word();
      check("t4_tl_clamp_7", 32'(tx_empty_intr), 32'd1);
      for (int i = 1; i < 7; i++) begin
         check("t4_order", 32'(tx_pop_data), 32'h040 + 32'(i));
         pop_word();
      end
      check("t4_tail", 32'(tx_pop_data), 32'h1AB);
      check("t4_tail_lvl", 32'(tx_level), 32'd1);
      pop_word();

      // Level 5 with overflow set, then disable flush
      tx_tl = 4'd2;
      for (int i = 0; i < 8; i++) push_word(9'h010 + 9'(i));
      push_word(9'h077);
      for (int i = 0; i < 3; i++) pop_word();
      check("t5_level5", 32'(tx_level), 32'd5);
      ic_enable    = 1'b0;
      tx_push      = 1'b1;
      tx_push_data = 9'h1EE;
      step();
      check("t5_fl_level", 32'(tx_level),    32'd0);
      check("t5_fl_empty", 32'(tx_empty),    32'd1);
      check("t5_fl_over",  32'(tx_over),     32'd1);
      check("t5_fl_data",  32'(tx_pop_data), 32'd0);
      step();
      check("t5_fl_hold_lvl",  32'(tx_level), 32'd0);
      check("t5_fl_hold_over", 32'(tx_over),  32'd1);
      tx_push   = 1'b0;
      ic_enable = 1'b1;
      step();
      push_word(9'h0C3);
      check("t5_post_head", 32'(tx_pop_data), 32'h0C3);
      check("t5_post_lvl",  32'(tx_level),    32'd1);

`ifdef I2C_TX_ABORT_FLUSH_EN
      for (int i = 0; i < 4; i++) push_word(9'h020 + 9'(i));
      check("t6_level5", 32'(tx_level), 32'd5);
      tx_abort     = 1'b1;
      tx_push      = 1'b1;
      tx_push_data = 9'h0AA;
      step();
      tx_abort = 1'b0;
      tx_push  = 1'b0;
      check("t6_ab_level", 32'(tx_level), 32'd0);
      check("t6_ab_empty", 32'(tx_empty), 32'd1);
      check("t6_ab_over",  32'(tx_over),  32'd1);
      push_word(9'h0C3);
`endif

      // Asynchronous reset between edges
      push_word(9'h011);
      #2;
      presetn = 1'b0;
      #1;
      check("t7_arst_level", 32'(tx_level), 32'd0);
      check("t7_arst_over",  32'(tx_over),  32'd0);
      check("t7_arst_empty", 32'(tx_empty), 32'd1);
      check("t7_arst_data",  32'(tx_pop_data), 32'd0);
      #2;
      presetn = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
